train_step_sequencer: RTL and testbench
=======================================

// Module: train_step_sequencer
// PURPOSE
//  Upstream scheduler for the FP/BP/WG training-phase controller. Holds a per-layer stride table and
//  drives one start pulse (in) plus a stable stride per layer step, walking num_layers layers for
//  num_iters iterations. Step completion is taken from the controller's in_en (3 falling edges = FP,BP,WG).
//  Provides busy/done status, abort with drain, and a watchdog on a stalled controller.
// PARAMETERS
//  MAX_LAYERS  16   depth of stride table
//  LAYER_W     4    index width, = clog2(MAX_LAYERS)
//  PHASES      3    in_en falling edges per layer step (FP,BP,WG)
//  TIMEOUT     255  max cycles in RUN/DRAIN without any in_en edge before error
//  TO_W        8    watchdog counter width
// PORTS
//  clk          in   1          clock, rising edge
//  fsm_rst_n    in   1          reset, asynchronous, active-low
//  cfg_we       in   1          stride table write strobe (ignored while busy)
//  cfg_addr     in   LAYER_W    table write address
//  cfg_stride   in   1          stride bit written
//  num_layers   in   LAYER_W+1  layers per iteration, sampled on accepted start
//  num_iters    in   8          iterations, sampled on accepted start
//  start        in   1          run request, accepted only in S_IDLE
//  abort        in   1          stop after current step completes
//  in_en        in   1          controller input-enable (phase activity)
//  in           out  1          one-cycle step start pulse to controller
//  stride       out  1          stride for current step, stable from ISSUE to end of RUN
//  layer_idx    out  LAYER_W    layer of current step
//  busy         out  1          high in any state but S_IDLE
//  done         out  1          one-cycle pulse, normal completion
//  aborted      out  1          one-cycle pulse, abort completion
//  err_timeout  out  1          sticky; cleared by next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, table 0, in_en_d 0, counters 0, state S_IDLE. All outputs registered.
//  fall = in_en_d & ~in_en; any_edge = in_en_d ^ in_en. in_en_d registered every cycle.
//  S_IDLE: start & (num_layers==0 | num_iters==0) -> done=1 next cycle, stay IDLE, no in.
//    start otherwise -> latch counts, layer_idx=0, iter=0, phase=0, clear err_timeout -> S_ISSUE.
//  S_ISSUE (1 cycle): in=1, stride=table[layer_idx], wdog=0 -> S_RUN.
//  S_RUN: phase++ on fall; wdog=0 on any_edge else wdog++.
//    fall & phase==PHASES-1: phase=0; if last layer & last iter -> S_IDLE, done=1;
//    else advance layer_idx (wrap to 0, iter++) -> S_GAP.
//    abort seen in RUN -> S_DRAIN (phase/wdog keep counting).
//  S_GAP (1 cycle, controller returns to IDLE) -> S_ISSUE; abort here -> S_IDLE, aborted=1.
//  S_DRAIN: as RUN, but step end -> S_IDLE, aborted=1; no further in.
//  Abort in S_ISSUE: pulse still issued, then S_DRAIN. Abort in S_IDLE ignored.
//  Watchdog: wdog==TIMEOUT in RUN/DRAIN -> S_IDLE, err_timeout=1, no done/aborted.
//  start while busy ignored; cfg_we while busy ignored; same-cycle start+abort in IDLE: start wins.
//  Timing with paired controller: step = 12 controller cycles; in pulses 14 cycles apart;
//    done high 1 cycle after the final WG falling edge.
// TESTING
//  T1 write stride[0]=0,[1]=1; num_layers=2,num_iters=1, start@c0 -> in@c1 (stride=0), in@c15 (stride=1), done@c28, busy 0@c28.
//  T2 num_layers=3,num_iters=2 -> 6 in pulses, layer_idx 0,1,2,0,1,2, single done pulse.
//  T3 num_layers=0, start -> done next cycle, in never asserted, busy stays 0.
//  T4 abort at mid BP of layer 0 (num_layers=4) -> no new in, aborted pulse 1 cycle after WG fall, done never.
//  T5 controller model holds in_en=1 forever after in -> err_timeout=1 after 255 idle cycles, busy 0; next start clears it.
//  T6 start and cfg_we during busy -> ignored; table readback via stride matches pre-run values.

Source files
------------

// File: rtl/train_step_sequencer_if.sv
// Bus between the training-step sequencer (master) and its environment: stride table
// configuration, run control, controller phase activity and status outputs.
interface train_step_sequencer_if #(
    parameter int LAYER_W = 4
);
    // Handshake: start is a level sampled on the clock edge and is accepted only while busy is 0.
    // Each accepted step produces exactly one single-cycle in pulse. The step is complete on the
    // third falling edge of in_en. done and aborted are one-cycle pulses that close a run.
    logic               cfg_we;
    logic [LAYER_W-1:0] cfg_addr;
    logic               cfg_stride;
    logic [LAYER_W:0]   num_layers;
    logic [7:0]         num_iters;
    logic               start;
    logic               abort;
    logic               in_en;
    logic               in;
    logic               stride;
    logic [LAYER_W-1:0] layer_idx;
    logic               busy;
    logic               done;
    logic               aborted;
    logic               err_timeout;

    modport master (
        input  cfg_we, cfg_addr, cfg_stride, num_layers, num_iters, start, abort, in_en,
        output in, stride, layer_idx, busy, done, aborted, err_timeout
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_stride, num_layers, num_iters, start, abort, in_en,
        input  in, stride, layer_idx, busy, done, aborted, err_timeout
    );
endinterface

// File: rtl/train_step_sequencer.sv
// Walks num_layers layer steps for num_iters iterations, issuing one start pulse per step to the
// FP/BP/WG controller and retiring each step on its third in_en falling edge.
module train_step_sequencer #(
    parameter int MAX_LAYERS = 16,
    parameter int LAYER_W    = 4,
    parameter int PHASES     = 3,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input  logic                   clk,
    input  logic                   fsm_rst_n,
    train_step_sequencer_if.master bus,
    output logic [2:0]             dbg_state_o
);
    localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [LAYER_W:0] ONE_L = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [MAX_LAYERS-1:0]   tbl_q, tbl_d;
    logic                    in_en_q;
    logic [LAYER_W-1:0]      layer_q, layer_d;
    logic [7:0]              iter_q, iter_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [TO_W-1:0]         wdog_q, wdog_d;
    logic [LAYER_W:0]        nlay_q, nlay_d;
    logic [7:0]              niter_q, niter_d;
    logic                    in_q, in_d;
    logic                    stride_q, stride_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    err_q, err_d;

    logic fall, any_edge, last_layer, last_iter;
    logic done_ev, abort_ev, to_ev, clr_err;

    assign fall       = in_en_q & ~bus.in_en;
    assign any_edge   = in_en_q ^ bus.in_en;
    assign last_layer = ({1'b0, layer_q} == (nlay_q - ONE_L));
    assign last_iter  = (iter_q == (niter_q - 8'd1));

    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            state_q   <= S_IDLE;
            tbl_q     <= '0;
            in_en_q   <= 1'b0;
            layer_q   <= '0;
            iter_q    <= '0;
            phase_q   <= '0;
            wdog_q    <= '0;
            nlay_q    <= '0;
            niter_q   <= '0;
            in_q      <= 1'b0;
            stride_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tbl_q     <= tbl_d;
            in_en_q   <= bus.in_en;
            layer_q   <= layer_d;
            iter_q    <= iter_d;
            phase_q   <= phase_d;
            wdog_q    <= wdog_d;
            nlay_q    <= nlay_d;
            niter_q   <= niter_d;
            in_q      <= in_d;
            stride_q  <= stride_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tbl_d    = tbl_q;
        layer_d  = layer_q;
        iter_d   = iter_q;
        phase_d  = phase_q;
        wdog_d   = wdog_q;
        nlay_d   = nlay_q;
        niter_d  = niter_q;
        done_ev  = 1'b0;
        abort_ev = 1'b0;
        to_ev    = 1'b0;
        clr_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_we) tbl_d[bus.cfg_addr] = bus.cfg_stride;
                // An empty run completes immediately without touching the controller.
                if (bus.start) begin
                    if (bus.num_layers == '0 || bus.num_iters == '0) begin
                        done_ev = 1'b1;
                    end else begin
                        nlay_d  = bus.num_layers;
                        niter_d = bus.num_iters;
                        layer_d = '0;
                        iter_d  = '0;
                        phase_d = '0;
                        clr_err = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = bus.abort ? S_DRAIN : S_RUN;
            end
            S_RUN, S_DRAIN: begin
                wdog_d = any_edge ? '0 : wdog_q + 1'b1;
                if (fall) phase_d = phase_q + 1'b1;
                if (wdog_q == TO_W'(TIMEOUT)) begin
                    state_d = S_IDLE;
                    to_ev   = 1'b1;
                end else if (fall && phase_q == PH_W'(PHASES - 1)) begin
                    phase_d = '0;
                    if (state_q == S_DRAIN || bus.abort) begin
                        state_d  = S_IDLE;
                        abort_ev = 1'b1;
                    end else if (last_layer && last_iter) begin
                        state_d = S_IDLE;
                        done_ev = 1'b1;
                    end else begin
                        if (last_layer) begin
                            layer_d = '0;
                            iter_d  = iter_q + 8'd1;
                        end else begin
                            layer_d = layer_q + 1'b1;
                        end
                        state_d = S_GAP;
                    end
                end else if (bus.abort) begin
                    state_d = S_DRAIN;
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_d  = S_IDLE;
                    abort_ev = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so in rises in the same cycle as S_ISSUE.
    always_comb begin
        in_d      = (state_d == S_ISSUE);
        stride_d  = (state_d == S_ISSUE) ? tbl_q[layer_d] : stride_q;
        busy_d    = (state_d != S_IDLE);
        done_d    = done_ev;
        aborted_d = abort_ev;
        err_d     = to_ev ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    assign bus.in          = in_q;
    assign bus.stride      = stride_q;
    assign bus.layer_idx   = layer_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.err_timeout = err_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_train_step_sequencer.sv
// Directed bench for train_step_sequencer with a paired FP/BP/WG controller model and a
// scoreboard of expected {layer_idx, stride} per issued step.
module tb_train_step_sequencer;
    localparam int LW = 4;

    logic       clk;
    logic       fsm_rst_n;
    logic [2:0] dbg_state;
    int         cyc;

    train_step_sequencer_if #(.LAYER_W(LW)) bus ();

    train_step_sequencer dut (
        .clk         (clk),
        .fsm_rst_n   (fsm_rst_n),
        .bus         (bus.master),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard state ----------------
    logic [LW:0] exp_q[$];
    logic        model_tbl[16];
    int          in_cyc[$];
    int          done_cnt;
    int          abt_cnt;
    int          errors;
    int          checks;
    logic        ctl_hang;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- controller model ----------------
    initial begin
        bus.in_en = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.in === 1'b1) begin
                if (ctl_hang) begin
                    @(posedge clk); #1 bus.in_en = 1'b1;
                    while (ctl_hang) begin @(posedge clk); #1; end
                    bus.in_en = 1'b0;
                end else begin
                    for (int p = 0; p < 3; p++) begin
                        repeat (3) begin @(posedge clk); #1 bus.in_en = 1'b1; end
                        @(posedge clk); #1 bus.in_en = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (fsm_rst_n) begin
                if (bus.in === 1'b1) begin
                    in_cyc.push_back(cyc);
                    if (exp_q.size() == 0) chk("unexpected_in", 32'(bus.layer_idx), 32'hFFFF);
                    else chk("step_layer_stride", {bus.layer_idx, bus.stride}, exp_q.pop_front());
                end
                if (bus.done === 1'b1) done_cnt++;
                if (bus.aborted === 1'b1) abt_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        in_cyc.delete();
        done_cnt = 0;
        abt_cnt  = 0;
    endtask

    task automatic cfg_write(input int addr, input logic val, input logic update_model);
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = LW'(addr);
        bus.cfg_stride = val;
        if (update_model) model_tbl[addr] = val;
        tick(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic start_run(input int nl, input int ni, input int max_push, input logic with_abort);
        int pushed = 0;
        for (int it = 0; it < ni; it++)
            for (int l = 0; l < nl; l++)
                if (pushed < max_push) begin
                    exp_q.push_back({LW'(l), model_tbl[l]});
                    pushed++;
                end
        bus.num_layers = (LW+1)'(nl);
        bus.num_iters  = 8'(ni);
        bus.start      = 1'b1;
        bus.abort      = with_abort;
        tick(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
        tick(2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0;
        int n;
        errors = 0; checks = 0; ctl_hang = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_stride = 1'b0;
        bus.num_layers = '0; bus.num_iters = '0; bus.start = 1'b0; bus.abort = 1'b0;
        clear_counts();
        fsm_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {bus.in, bus.stride, bus.layer_idx, bus.busy, bus.done, bus.aborted, bus.err_timeout}, 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);
        fsm_rst_n = 1'b1;
        tick(1);

        // T1: two layers, one iteration, exact timing
        for (int a = 2; a < 16; a++) cfg_write(a, logic'($urandom_range(0, 1)), 1'b1);
        cfg_write(0, 1'b0, 1'b1);
        cfg_write(1, 1'b1, 1'b1);
        clear_counts();
        c0 = cyc;
        start_run(2, 1, 2, 1'b0);
        n = 0;
        while (cyc < c0 + 28 && n < 60) begin tick(1); n++; end
        chk("t1_done_c28", 32'(bus.done), 32'd1);
        chk("t1_busy_c28", 32'(bus.busy), 32'd0);
        chk("t1_in_count", 32'(in_cyc.size()), 32'd2);
        if (in_cyc.size() == 2) begin
            chk("t1_in0_cycle", 32'(in_cyc[0] - c0), 32'd1);
            chk("t1_in1_cycle", 32'(in_cyc[1] - c0), 32'd15);
        end
        tick(2);
        chk("t1_exp_empty", 32'(exp_q.size()), 32'd0);

        // T2: three layers, two iterations
        clear_counts();
        start_run(3, 2, 6, 1'b0);
        wait_idle("t2_idle_timeout", 200);
        chk("t2_in_count", 32'(in_cyc.size()), 32'd6);
        chk("t2_done_count", 32'(done_cnt), 32'd1);
        chk("t2_exp_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i + 1 < in_cyc.size(); i++)
            chk("t2_in_spacing", 32'(in_cyc[i+1] - in_cyc[i]), 32'd14);
        chk("t2_state_idle", 32'(dbg_state), 32'd0);

        // T3: zero layers / zero iterations complete at once
        clear_counts();
        start_run(0, 1, 0, 1'b0);
        chk("t3_done_next", 32'(bus.done), 32'd1);
        chk("t3_busy_low", 32'(bus.busy), 32'd0);
        tick(3);
        start_run(2, 0, 0, 1'b0);
        chk("t3b_done_next", 32'(bus.done), 32'd1);
        tick(5);
        chk("t3_no_in", 32'(in_cyc.size()), 32'd0);
        chk("t3_done_count", 32'(done_cnt), 32'd2);
        chk("t3_busy_stays_low", 32'(bus.busy), 32'd0);

        // T4: abort during BP of layer 0
        clear_counts();
        c0 = cyc;
        start_run(4, 1, 1, 1'b0);
        while (cyc < c0 + 7) tick(1);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        while (cyc < c0 + 14) tick(1);
        chk("t4_aborted_pulse", 32'(bus.aborted), 32'd1);
        chk("t4_busy_low", 32'(bus.busy), 32'd0);
        chk("t4_no_done", 32'(bus.done), 32'd0);
        tick(30);
        chk("t4_in_count", 32'(in_cyc.size()), 32'd1);
        chk("t4_done_count", 32'(done_cnt), 32'd0);
        chk("t4_abort_count", 32'(abt_cnt), 32'd1);
        chk("t4_exp_empty", 32'(exp_q.size()), 32'd0);

        // T5: stalled controller trips the watchdog
        clear_counts();
        ctl_hang = 1'b1;
        c0 = cyc;
        start_run(1, 1, 1, 1'b0);
        while (cyc < c0 + 250) tick(1);
        chk("t5_err_not_early", 32'(bus.err_timeout), 32'd0);
        chk("t5_busy_before", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 40) begin tick(1); n++; end
        chk("t5_err_set", 32'(bus.err_timeout), 32'd1);
        chk("t5_err_cycle", 32'(cyc - c0), 32'd259);
        chk("t5_busy_after", 32'(bus.busy), 32'd0);
        tick(2);
        chk("t5_no_done_abort", 32'(done_cnt + abt_cnt), 32'd0);
        ctl_hang = 1'b0;
        tick(3);
        chk("t5_err_sticky", 32'(bus.err_timeout), 32'd1);
        clear_counts();
        start_run(1, 1, 1, 1'b0);
        chk("t5_err_cleared", 32'(bus.err_timeout), 32'd0);
        wait_idle("t5_idle_timeout", 100);
        chk("t5_rerun_done", 32'(done_cnt), 32'd1);

        // T6: cfg writes and start while busy are ignored
        clear_counts();
        start_run(3, 1, 3, 1'b0);
        tick(2);
        for (int a = 0; a < 3; a++) cfg_write(a, ~model_tbl[a], 1'b0);
        bus.num_layers = 5'd1;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_idle("t6_idle_timeout", 200);
        chk("t6_in_count", 32'(in_cyc.size()), 32'd3);
        chk("t6_done_count", 32'(done_cnt), 32'd1);
        clear_counts();
        start_run(3, 1, 3, 1'b0);
        wait_idle("t6_readback_timeout", 200);
        chk("t6_readback_count", 32'(in_cyc.size()), 32'd3);
        chk("t6_exp_empty", 32'(exp_q.size()), 32'd0);

        // T7: start and abort in the same idle cycle, start wins
        clear_counts();
        start_run(2, 1, 2, 1'b1);
        wait_idle("t7_idle_timeout", 200);
        chk("t7_done_count", 32'(done_cnt), 32'd1);
        chk("t7_abort_count", 32'(abt_cnt), 32'd0);
        chk("t7_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
